// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Owns the byte-wide RAM port and shares it between the icache line
//            refill, the dcache line refill/writeback and uncached IO accesses.
//            Each transaction is serialised into consecutive byte cycles; read
//            data is assembled into a line (lineOut) or an IO word (ioDataOut).
//            Fixed priority io > dc > ic, requests sampled only in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int BLOCK_WIDTH = 4,                 // log2 of line size in bytes (>= 2)
  parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH     // line size in bytes
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      clearIn,
  input  logic [7:0]                memIn,
  output logic [31:0]               memAddr,
  output logic [7:0]                memOut,
  output logic                      readWriteOut,
  input  logic                      icReq,
  input  logic [31-BLOCK_WIDTH:0]   icAddr,
  output logic                      icDone,
  input  logic                      dcReq,
  input  logic                      dcWrite,
  input  logic [31-BLOCK_WIDTH:0]   dcAddr,
  input  logic [BLOCK_SIZE*8-1:0]   dcLineIn,
  output logic                      dcDone,
  output logic [BLOCK_SIZE*8-1:0]   lineOut,
  input  logic                      ioReq,
  input  logic                      ioWrite,
  input  logic [1:0]                ioSize,
  input  logic [31:0]               ioAddr,
  input  logic [31:0]               ioDataIn,
  output logic                      ioDone,
  output logic [31:0]               ioDataOut,
  output logic                      busy
);

  localparam int LW = BLOCK_SIZE * 8;   // line width in bits
  localparam int CW = BLOCK_WIDTH + 1;  // byte counter width, holds 0..BLOCK_SIZE

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_IC = 2'd0,
    SRC_DC = 2'd1,
    SRC_IO = 2'd2
  } src_t;

  state_t          state_q, state_d;
  src_t            src_q;
  logic [31:0]     base_q;
  logic [CW-1:0]   len_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   cap_idx;
  logic [LW-1:0]   wbuf_q;
  logic [LW-1:0]   rbuf_q;
  logic [LW-1:0]   rbuf_next;

  // Acceptance decode
  logic            io_go;
  logic            ic_go;
  logic            acc_valid;
  logic            accept;
  src_t            acc_src;
  logic            acc_write;
  logic [31:0]     acc_base;
  logic [CW-1:0]   acc_len;
  logic [LW-1:0]   acc_wdata;
  logic [CW-1:0]   io_len;

  // Transfer progress
  logic            ic_abort;
  logic            rd_last;
  logic            wr_last;

  assign busy    = (state_q != IDLE);
  assign io_go   = ioReq && (ioSize != 2'b00);
  assign ic_go   = icReq && !clearIn;
  assign accept  = (state_q == IDLE) && acc_valid;
  assign cnt_inc = cnt_q + CW'(1);
  // Byte k-1 of a read arrives one cycle after its address, i.e. while the
  // counter already reads k; hence the capture slot lags the counter by one.
  assign cap_idx = cnt_q - CW'(1);

  assign ic_abort = (state_q == READ) && (src_q == SRC_IC) && clearIn;
  assign rd_last  = (state_q == READ) && (cnt_q == len_q);
  assign wr_last  = (state_q == WRITE) && (cnt_inc == len_q);

  // IO byte count from the size code (00 never reaches acceptance)
  always_comb begin
    io_len = CW'(4);
    case (ioSize)
      2'b01:   io_len = CW'(1);
      2'b10:   io_len = CW'(2);
      default: io_len = CW'(4);
    endcase
  end

  // Fixed-priority request selection: io > dc > ic
  always_comb begin
    acc_valid = 1'b0;
    acc_src   = SRC_IC;
    acc_write = 1'b0;
    acc_base  = '0;
    acc_len   = '0;
    acc_wdata = '0;
    if (io_go) begin
      acc_valid = 1'b1;
      acc_src   = SRC_IO;
      acc_write = ioWrite;
      acc_base  = ioAddr;
      acc_len   = io_len;
      acc_wdata = LW'(ioDataIn);
    end else if (dcReq) begin
      acc_valid = 1'b1;
      acc_src   = SRC_DC;
      acc_write = dcWrite;
      acc_base  = {dcAddr, {BLOCK_WIDTH{1'b0}}};
      acc_len   = CW'(BLOCK_SIZE);
      acc_wdata = dcLineIn;
    end else if (ic_go) begin
      acc_valid = 1'b1;
      acc_src   = SRC_IC;
      acc_write = 1'b0;
      acc_base  = {icAddr, {BLOCK_WIDTH{1'b0}}};
      acc_len   = CW'(BLOCK_SIZE);
    end
  end

  // Read buffer with the byte arriving this cycle merged in
  always_comb begin
    rbuf_next = rbuf_q;
    if ((state_q == READ) && (cnt_q != '0)) begin
      rbuf_next[{cap_idx, 3'b000} +: 8] = memIn;
    end
  end

  // Next-state logic; DONE always falls back to IDLE without sampling requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = acc_write ? WRITE : READ;
        end
      end
      READ: begin
        if (ic_abort) begin
          state_d = IDLE;
        end else if (rd_last) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        if (wr_last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM port drive, byte counter, data buffers, returned data and done pulses
  always_ff @(posedge clkIn or posedge resetIn) begin
    if (resetIn) begin
      src_q        <= SRC_IC;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      wbuf_q       <= '0;
      rbuf_q       <= '0;
      memAddr      <= '0;
      memOut       <= '0;
      readWriteOut <= 1'b0;
      icDone       <= 1'b0;
      dcDone       <= 1'b0;
      ioDone       <= 1'b0;
      lineOut      <= '0;
      ioDataOut    <= '0;
    end else begin
      icDone <= 1'b0;
      dcDone <= 1'b0;
      ioDone <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            src_q        <= acc_src;
            base_q       <= acc_base;
            len_q        <= acc_len;
            cnt_q        <= '0;
            rbuf_q       <= '0;            // keeps IO load bytes above size at zero
            memAddr      <= acc_base;
            readWriteOut <= acc_write;
            memOut       <= acc_write ? acc_wdata[7:0] : 8'h00;
            wbuf_q       <= acc_wdata >> 8; // byte 0 is already on memOut
          end
        end
        READ: begin
          cnt_q  <= cnt_inc;
          rbuf_q <= rbuf_next;
          if (ic_abort || rd_last || (cnt_inc >= len_q)) begin
            memAddr <= '0;
          end else begin
            memAddr <= base_q + 32'(cnt_inc);
          end
          if (!ic_abort && rd_last) begin
            case (src_q)
              SRC_IC: begin
                icDone  <= 1'b1;
                lineOut <= rbuf_next;
              end
              SRC_DC: begin
                dcDone  <= 1'b1;
                lineOut <= rbuf_next;
              end
              default: begin
                ioDone    <= 1'b1;
                ioDataOut <= rbuf_next[31:0];
              end
            endcase
          end
        end
        WRITE: begin
          cnt_q <= cnt_inc;
          if (wr_last) begin
            memAddr      <= '0;
            memOut       <= 8'h00;
            readWriteOut <= 1'b0;
            case (src_q)
              SRC_IC:  icDone <= 1'b1;
              SRC_DC:  dcDone <= 1'b1;
              default: ioDone <= 1'b1;
            endcase
          end else begin
            memAddr <= base_q + 32'(cnt_inc);
            memOut  <= wbuf_q[7:0];
            wbuf_q  <= wbuf_q >> 8;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a one-cycle-latency RAM model
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int BW = 4;
  localparam int BS = 16;

  logic            clkIn = 1'b0;
  logic            resetIn = 1'b1;
  logic            clearIn = 1'b0;
  logic [7:0]      memIn;
  logic [31:0]     memAddr;
  logic [7:0]      memOut;
  logic            readWriteOut;
  logic            icReq = 1'b0;
  logic [31-BW:0]  icAddr = '0;
  logic            icDone;
  logic            dcReq = 1'b0;
  logic            dcWrite = 1'b0;
  logic [31-BW:0]  dcAddr = '0;
  logic [BS*8-1:0] dcLineIn = '0;
  logic            dcDone;
  logic [BS*8-1:0] lineOut;
  logic            ioReq = 1'b0;
  logic            ioWrite = 1'b0;
  logic [1:0]      ioSize = 2'b00;
  logic [31:0]     ioAddr = '0;
  logic [31:0]     ioDataIn = '0;
  logic            ioDone;
  logic [31:0]     ioDataOut;
  logic            busy;

  mem_arbiter #(.BLOCK_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .memIn(memIn),
    .memAddr(memAddr), .memOut(memOut), .readWriteOut(readWriteOut),
    .icReq(icReq), .icAddr(icAddr), .icDone(icDone),
    .dcReq(dcReq), .dcWrite(dcWrite), .dcAddr(dcAddr), .dcLineIn(dcLineIn),
    .dcDone(dcDone), .lineOut(lineOut),
    .ioReq(ioReq), .ioWrite(ioWrite), .ioSize(ioSize), .ioAddr(ioAddr),
    .ioDataIn(ioDataIn), .ioDone(ioDone), .ioDataOut(ioDataOut), .busy(busy)
  );

  always #5 clkIn = ~clkIn;

  typedef struct {
    int           src;   // 0 ic, 1 dc, 2 io
    int           lat;   // cycles from acceptance edge to done edge
    logic [127:0] data;
    bit           chk;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  raddr_q[$];
  logic [39:0]  wr_q[$];
  logic [7:0]   ram[int unsigned];      // RAM contents as written by the DUT
  logic [7:0]   ref_mem[int unsigned];  // bench's own view of RAM contents
  logic [7:0]   mem_q = 8'h00;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  bit           busy_prev = 1'b0;
  int           done_cnt[3] = '{0, 0, 0};
  int           acc_log[$];
  int           done_log[$];
  logic [127:0] last_line = '0;
  exp_t         mon_e;
  int           mon_src;
  logic [127:0] mon_got;
  logic [39:0]  mon_w;
  logic [31:0]  mon_a;

  assign memIn = mem_q;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[7:0];
  endfunction

  // Expected read: data from the bench's RAM view, addresses in order, latency n+1
  task automatic exp_read(input int src, input logic [31:0] base, input int n);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) begin
      e.data[i*8 +: 8] = ref_rd(base + 32'(i));
      raddr_q.push_back(base + 32'(i));
    end
    e.src = src;
    e.lat = n + 1;
    e.chk = 1'b1;
    sb.push_back(e);
    if (src != 2) last_line = e.data;
  endtask

  // Expected write: one RAM write per byte, latency n
  task automatic exp_write(input int src, input logic [31:0] base, input int n,
                           input logic [127:0] d);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      ref_mem[base + 32'(i)] = d[i*8 +: 8];
      wr_q.push_back({base + 32'(i), d[i*8 +: 8]});
    end
    e.src  = src;
    e.lat  = n;
    e.chk  = 1'b0;
    e.data = '0;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int src, input int start, input string tag);
    int t = 0;
    while (done_cnt[src] == start && t < 120) begin
      @(negedge clkIn);
      t++;
    end
    if (done_cnt[src] == start) check(tag, 128'(done_cnt[src] - start), 128'd1);
  endtask

  // RAM model: registered read data, writes logged against the expected queue
  always @(posedge clkIn) begin
    cyc = cyc + 1;
    if (!resetIn) begin
      if (readWriteOut) begin
        ram[memAddr] = memOut;
        if (wr_q.size() == 0) begin
          check("write_extra", 128'(wr_q.size()), 128'd1);
        end else begin
          mon_w = wr_q.pop_front();
          check("write_addr_data", {memAddr, memOut}, mon_w);
        end
      end else if (memAddr != 32'h0) begin
        if (raddr_q.size() == 0) begin
          check("read_addr_extra", 128'(raddr_q.size()), 128'd1);
        end else begin
          mon_a = raddr_q.pop_front();
          check("read_addr", memAddr, mon_a);
        end
      end
    end
    mem_q <= ram_rd(memAddr);
  end

  // Output monitor: acceptance timing and done pulses popped from the scoreboard
  always @(negedge clkIn) begin
    if (!resetIn) begin
      if (busy && !busy_prev) begin
        acc_cyc = cyc;
        acc_log.push_back(cyc);
      end
      if (icDone || dcDone || ioDone) begin
        check("done_onehot", 128'(int'(icDone) + int'(dcDone) + int'(ioDone)), 128'd1);
        mon_src = ioDone ? 2 : (dcDone ? 1 : 0);
        mon_got = (mon_src == 2) ? 128'(ioDataOut) : lineOut;
        done_log.push_back(cyc);
        done_cnt[mon_src]++;
        check("done_rw", 128'(readWriteOut), 128'd0);
        check("done_addr", 128'(memAddr), 128'd0);
        if (sb.size() == 0) begin
          check("done_extra", 128'(sb.size()), 128'd1);
        end else begin
          mon_e = sb.pop_front();
          check("done_src", 128'(mon_src), 128'(mon_e.src));
          check("done_latency", 128'(cyc - acc_cyc), 128'(mon_e.lat));
          if (mon_e.chk) check("done_data", mon_got, mon_e.data);
        end
      end
    end
    busy_prev = busy;
  end

  initial begin
    logic [127:0] d;
    int s0, s1, s2;

    // ---- reset state ----
    repeat (3) @(negedge clkIn);
    check("rst_memAddr", 128'(memAddr), 128'd0);
    check("rst_memOut", 128'(memOut), 128'd0);
    check("rst_rw", 128'(readWriteOut), 128'd0);
    check("rst_dones", 128'({icDone, dcDone, ioDone}), 128'd0);
    check("rst_lineOut", lineOut, 128'd0);
    check("rst_ioDataOut", 128'(ioDataOut), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    resetIn = 1'b0;
    @(negedge clkIn);

    // ---- icache line refill from 0x1000 ----
    s0 = done_cnt[0];
    exp_read(0, 32'h0000_1000, 16);
    icReq = 1'b1; icAddr = 28'h000_0100;
    @(negedge clkIn);
    icAddr = 28'hFFF_FFFF;
    wait_done(0, s0, "ic_timeout");
    icReq = 1'b0;
    check("ic_line", lineOut, 128'h0F0E0D0C0B0A09080706050403020100);
    check("ic_addr_left", 128'(raddr_q.size()), 128'd0);

    // ---- dcache writeback to 0x2000 ----
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'hA0 + 8'(i);
    s1 = done_cnt[1];
    exp_write(1, 32'h0000_2000, 16, d);
    dcReq = 1'b1; dcWrite = 1'b1; dcAddr = 28'h000_0200; dcLineIn = d;
    @(negedge clkIn);
    dcLineIn = ~d; dcAddr = 28'h123_4567;
    wait_done(1, s1, "dc_wb_timeout");
    dcReq = 1'b0; dcWrite = 1'b0;
    check("dc_wb_left", 128'(wr_q.size()), 128'd0);

    // ---- IO store word, then half load from an odd address ----
    s2 = done_cnt[2];
    exp_write(2, 32'h0003_0000, 4, 128'hDEADBEEF);
    ioReq = 1'b1; ioWrite = 1'b1; ioSize = 2'b11; ioAddr = 32'h0003_0000; ioDataIn = 32'hDEADBEEF;
    @(negedge clkIn);
    ioDataIn = 32'h0;
    wait_done(2, s2, "io_st_timeout");
    ioReq = 1'b0;
    s2 = done_cnt[2];
    exp_read(2, 32'h0003_0001, 2);
    ioReq = 1'b1; ioWrite = 1'b0; ioSize = 2'b10; ioAddr = 32'h0003_0001;
    wait_done(2, s2, "io_ld_timeout");
    ioReq = 1'b0;
    check("io_half", 128'(ioDataOut), 128'h0000ADBE);

    // ---- simultaneous requests: io, then dc, then ic ----
    acc_log.delete();
    done_log.delete();
    exp_read(2, 32'h0003_0003, 1);
    exp_read(1, 32'h0000_4000, 16);
    exp_read(0, 32'h0000_3080, 16);
    s0 = done_cnt[0]; s1 = done_cnt[1]; s2 = done_cnt[2];
    @(negedge clkIn);
    ioReq = 1'b1; ioWrite = 1'b0; ioSize = 2'b01; ioAddr = 32'h0003_0003;
    dcReq = 1'b1; dcWrite = 1'b0; dcAddr = 28'h000_0400;
    icReq = 1'b1; icAddr = 28'h000_0308;
    fork
      begin wait_done(2, s2, "mix_io_timeout"); ioReq = 1'b0; end
      begin wait_done(1, s1, "mix_dc_timeout"); dcReq = 1'b0; end
      begin wait_done(0, s0, "mix_ic_timeout"); icReq = 1'b0; end
    join
    check("mix_io_byte", 128'(ioDataOut), 128'h000000DE);
    check("mix_accepts", 128'(acc_log.size()), 128'd3);
    check("mix_dones", 128'(done_log.size()), 128'd3);
    if (acc_log.size() == 3 && done_log.size() == 3) begin
      check("mix_gap1", 128'(acc_log[1] - done_log[0]), 128'd2);
      check("mix_gap2", 128'(acc_log[2] - done_log[1]), 128'd2);
    end
    check("mix_sb_empty", 128'(sb.size()), 128'd0);

    // ---- clearIn in the 5th cycle of an icache read ----
    for (int i = 0; i < 5; i++) raddr_q.push_back(32'h0000_5000 + 32'(i));
    @(negedge clkIn);
    icReq = 1'b1; icAddr = 28'h000_0500;
    repeat (5) @(negedge clkIn);
    clearIn = 1'b1; icReq = 1'b0;
    @(negedge clkIn);
    clearIn = 1'b0;
    check("clr_busy", 128'(busy), 128'd0);
    check("clr_addr", 128'(memAddr), 128'd0);
    check("clr_icDone", 128'(icDone), 128'd0);
    check("clr_lineOut", lineOut, last_line);
    check("clr_addr_left", 128'(raddr_q.size()), 128'd0);
    // clearIn held in IDLE blocks icReq
    clearIn = 1'b1; icReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clkIn);
      check("clr_hold_busy", 128'(busy), 128'd0);
    end
    icReq = 1'b0; clearIn = 1'b0;
    @(negedge clkIn);

    // ---- asynchronous reset mid writeback ----
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'h50 + 8'(i);
    for (int i = 0; i < 5; i++) begin
      ref_mem[32'h0000_6000 + 32'(i)] = d[i*8 +: 8];
      wr_q.push_back({32'h0000_6000 + 32'(i), d[i*8 +: 8]});
    end
    dcReq = 1'b1; dcWrite = 1'b1; dcAddr = 28'h000_0600; dcLineIn = d;
    repeat (6) @(negedge clkIn);
    #2 resetIn = 1'b1;
    #1;
    check("arst_addr", 128'(memAddr), 128'd0);
    check("arst_memOut", 128'(memOut), 128'd0);
    check("arst_rw", 128'(readWriteOut), 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_lineOut", lineOut, 128'd0);
    dcReq = 1'b0; dcWrite = 1'b0;
    @(negedge clkIn);
    @(negedge clkIn);
    resetIn = 1'b0;
    check("arst_wr_left", 128'(wr_q.size()), 128'd0);
    @(negedge clkIn);
    s2 = done_cnt[2];
    exp_read(2, 32'h0003_0000, 1);
    ioReq = 1'b1; ioWrite = 1'b0; ioSize = 2'b01; ioAddr = 32'h0003_0000;
    wait_done(2, s2, "post_rst_timeout");
    ioReq = 1'b0;
    check("post_rst_byte", 128'(ioDataOut), 128'h000000EF);

    repeat (3) @(negedge clkIn);
    check("end_sb_empty", 128'(sb.size()), 128'd0);
    check("end_raddr_empty", 128'(raddr_q.size()), 128'd0);
    check("end_wr_empty", 128'(wr_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
